// File: rtl/ifetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order pc tracking and a
// 2-entry {pc, instr} output FIFO. Optional macro IFETCH_ALIGN_FAULT_EN adds fetch_fault.
`timescale 1ns/1ps
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_ALIGN_FAULT_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  outst_q, outst_d;
    logic        pcq_wr_q, pcq_wr_d;
    logic        pcq_rd_q, pcq_rd_d;
    logic [31:0] pcq0_q, pcq0_d;
    logic [31:0] pcq1_q, pcq1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic        fault_q, fault_d;

    logic        req_fire;
    logic        rsp_fire;
    logic        push;
    logic        pop;
    logic        fault_set;
    logic [31:0] rsp_pc;
    logic [31:0] redir_target;

    assign req_fire     = imem_req_valid & imem_req_ready;
    // A response with nothing outstanding is a memory protocol error; ignore it.
    assign rsp_fire     = imem_rsp_valid & (outst_q != 2'd0);
    assign rsp_pc       = pcq_rd_q ? pcq1_q : pcq0_q;
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
    assign pop          = out_valid & out_ready;
    assign push         = rsp_fire & (state_q == ST_RUN) & ~redirect_valid & ~fault_q;

`ifdef IFETCH_ALIGN_FAULT_EN
    assign fault_set   = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault_q;
`else
    assign fault_set   = 1'b0;
`endif

    assign imem_req_addr = pc_q;
    assign out_valid     = (cnt_q != 2'd0);
    assign out_pc        = head_pc_q;
    assign out_instr     = head_instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain exits as soon as the last stale response has retired.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (outst_d != 2'd0) ? ST_DRAIN : ST_RUN;
        end else if ((state_q == ST_DRAIN) && (outst_d == 2'd0)) begin
            state_d = ST_RUN;
        end
    end

    // Credit rule: in-flight requests plus buffered entries never exceed the FIFO depth.
    always_comb begin
        imem_req_valid = rst_n & (state_q == ST_RUN) & ~fault_q &
                         (({1'b0, outst_q} + {1'b0, cnt_q}) < 3'd2);
    end

    always_comb begin
        pc_d     = pc_q;
        outst_d  = outst_q + {1'b0, req_fire} - {1'b0, rsp_fire};
        pcq_wr_d = pcq_wr_q;
        pcq_rd_d = pcq_rd_q;
        pcq0_d   = pcq0_q;
        pcq1_d   = pcq1_q;
        fault_d  = fault_q | fault_set;
        if (req_fire) begin
            pc_d     = pc_q + 32'd4;
            pcq_wr_d = ~pcq_wr_q;
            if (pcq_wr_q) begin
                pcq1_d = pc_q;
            end else begin
                pcq0_d = pc_q;
            end
        end
        if (rsp_fire) begin
            pcq_rd_d = ~pcq_rd_q;
        end
        if (redirect_valid) begin
            pc_d = redir_target;
        end
    end

    // Head entry is a dedicated register so out_pc/out_instr come straight from flops.
    always_comb begin
        cnt_d        = cnt_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        if (redirect_valid) begin
            cnt_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = rsp_pc;
                        tail_instr_d = imem_rsp_data;
                    end else begin
                        head_pc_d    = rsp_pc;
                        head_instr_d = imem_rsp_data;
                    end
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_pc_d    = rsp_pc;
                        head_instr_d = imem_rsp_data;
                    end else begin
                        tail_pc_d    = rsp_pc;
                        tail_instr_d = imem_rsp_data;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    cnt_d        = cnt_q - 2'd1;
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            outst_q      <= 2'd0;
            pcq_wr_q     <= 1'b0;
            pcq_rd_q     <= 1'b0;
            cnt_q        <= 2'd0;
            head_pc_q    <= 32'd0;
            head_instr_q <= 32'd0;
            fault_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            outst_q      <= outst_d;
            pcq_wr_q     <= pcq_wr_d;
            pcq_rd_q     <= pcq_rd_d;
            cnt_q        <= cnt_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            fault_q      <= fault_d;
        end
    end

    // Payload-only storage; validity is tracked by the reset counters and pointers.
    always_ff @(posedge clk) begin
        pcq0_q       <= pcq0_d;
        pcq1_q       <= pcq1_d;
        tail_pc_q    <= tail_pc_d;
        tail_instr_q <= tail_instr_d;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: randomized memory/downstream/redirect stimulus
// against a queue-based reference model; a second instance covers PC wrap from reset.
`timescale 1ns/1ps
module tb_ifetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        redirect_valid, out_valid, out_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_instr, out_pc;
    logic        w_rst_n, w_req_valid, w_req_ready, w_rsp_valid;
    logic        w_redirect_valid, w_out_valid, w_out_ready;
    logic [31:0] w_req_addr, w_rsp_data, w_redirect_pc, w_out_instr, w_out_pc;
`ifdef IFETCH_ALIGN_FAULT_EN
    logic        fetch_fault, w_fetch_fault;
`endif

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef IFETCH_ALIGN_FAULT_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .redirect_valid(w_redirect_valid),
        .redirect_pc(w_redirect_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc)
`ifdef IFETCH_ALIGN_FAULT_EN
        , .fetch_fault(w_fetch_fault)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        osq[$];
    ent_t        exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] w_log[$];
    int          vectors = 0, miscompares = 0, cyc = 0, last_due = 0;
    logic [31:0] model_pc;
    bit          model_fault, mon_popped, force_redir, w_done, w_pend;
    logic [31:0] force_target, w_paddr;
    int          lat_min = 1, lat_max = 1, ready_pct = 100, mreq_pct = 100, redir_permille = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'h0000_1000 + ($urandom_range(0, 63) << 2);
            1:       t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            2:       t = $urandom & 32'hFFFF_FFFC;
            default: t = $urandom_range(0, 1023);
        endcase
`ifdef IFETCH_ALIGN_FAULT_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares and retires the scoreboard head whenever the DUT presents output.
    always @(negedge clk) begin
        #1;
        mon_popped = 1'b0;
        if (rst_n === 1'b1) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() != 0)});
            if (out_valid && exp_q.size() != 0) begin
                check("out_pc", out_pc, exp_q[0].pc);
                check("out_instr", out_instr, exp_q[0].instr);
                if (out_ready) begin
                    pop_log.push_back(out_pc);
                    void'(exp_q.pop_front());
                    mon_popped = 1'b1;
                end
            end
        end
    end

    task automatic model_step();
        int   fifo_pre, due;
        bit   stale_any, exp_rv;
        req_t r;
        ent_t e;
        fifo_pre  = exp_q.size() + (mon_popped ? 1 : 0);
        stale_any = 1'b0;
        foreach (osq[i]) if (osq[i].stale) stale_any = 1'b1;
        exp_rv = !model_fault && !stale_any && ((osq.size() + fifo_pre) < 2);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
`ifdef IFETCH_ALIGN_FAULT_EN
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, model_fault});
`endif
        if (imem_rsp_valid && osq.size() != 0) begin
            r = osq.pop_front();
            if (!r.stale && !redirect_valid && !model_fault) begin
                e.pc    = r.pc;
                e.instr = mem_word(r.pc);
                exp_q.push_back(e);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, model_pc);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.pc    = model_pc;
            r.addr  = imem_req_addr;
            r.due   = due;
            r.stale = 1'b0;
            osq.push_back(r);
            model_pc = model_pc + 32'd4;
        end
        if (redirect_valid) begin
            foreach (osq[i]) osq[i].stale = 1'b1;
            exp_q.delete();
`ifdef IFETCH_ALIGN_FAULT_EN
            if (redirect_pc[1:0] != 2'b00) model_fault = 1'b1;
`endif
            model_pc = {redirect_pc[31:2], 2'b00};
        end
    endtask

    // One clock: drive at the falling edge, update the model once the monitor has run.
    task automatic cycle();
        if (rst_n) begin
            imem_rsp_valid = (osq.size() != 0) && (osq[0].due <= cyc);
            imem_rsp_data  = imem_rsp_valid ? mem_word(osq[0].addr) : $urandom;
            out_ready      = int'($urandom_range(0, 99)) < ready_pct;
            imem_req_ready = int'($urandom_range(0, 99)) < mreq_pct;
            if (force_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_target;
                force_redir    = 1'b0;
            end else if (int'($urandom_range(0, 999)) < redir_permille) begin
                redirect_valid = 1'b1;
                redirect_pc    = rand_target();
            end else begin
                redirect_valid = 1'b0;
                redirect_pc    = $urandom;
            end
        end
        #2;
        if (rst_n) model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        @(negedge clk);
        @(negedge clk);
        osq.delete();
        exp_q.delete();
        model_pc    = 32'h0000_0000;
        model_fault = 1'b0;
        mon_popped  = 1'b0;
        last_due    = cyc;
        rst_n       = 1'b1;
    endtask

    // Second instance: 1-cycle memory, always-ready sink, checks PC wrap out of reset.
    initial begin
        w_rst_n = 1'b0; w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 32'd0;
        w_redirect_valid = 1'b0; w_redirect_pc = 32'd0; w_out_ready = 1'b1;
        w_done = 1'b0; w_pend = 1'b0; w_paddr = 32'd0;
        repeat (3) @(negedge clk);
        w_rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            w_rsp_valid = w_pend;
            w_rsp_data  = mem_word(w_paddr);
            #1;
            w_pend = w_req_valid && w_req_ready;
            if (w_pend) begin
                w_paddr = w_req_addr;
                w_log.push_back(w_req_addr);
            end
            @(negedge clk);
        end
        w_done = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
        force_redir = 1'b0; force_target = 32'd0; model_pc = 32'd0; model_fault = 1'b0;
        @(negedge clk);

        // In-order fetch from reset with a 1-cycle memory and an always-ready sink.
        lat_min = 1; lat_max = 1; ready_pct = 100; mreq_pct = 100; redir_permille = 0;
        do_reset();
        pop_log.delete();
        repeat (12) cycle();
        check("a_npops", {31'b0, (pop_log.size() >= 3)}, 32'd1);
        if (pop_log.size() >= 3)
            for (int i = 0; i < 3; i++) check($sformatf("a_pc%0d", i), pop_log[i], 32'(i * 4));

        // Downstream stall: two entries held, requests blocked, nothing lost on resume.
        ready_pct = 0;
        do_reset();
        pop_log.delete();
        repeat (10) cycle();
        check("b_held_valid", {31'b0, out_valid}, 32'd1);
        check("b_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        ready_pct = 100;
        repeat (8) cycle();
        check("b_npops", {31'b0, (pop_log.size() >= 3)}, 32'd1);
        if (pop_log.size() >= 3)
            for (int i = 0; i < 3; i++) check($sformatf("b_pc%0d", i), pop_log[i], 32'(i * 4));

        // Redirect with two requests in flight on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        do_reset();
        n = 0;
        while (osq.size() < 2 && n < 20) begin cycle(); n++; end
        check("c_two_outstanding", osq.size(), 32'd2);
        force_redir = 1'b1; force_target = 32'h0000_0100;
        cycle();
        pop_log.delete();
        n = 0;
        while (pop_log.size() == 0 && n < 40) begin cycle(); n++; end
        check("c_first_pc", (pop_log.size() != 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0100);

        // Misaligned redirect target.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (6) cycle();
        force_redir = 1'b1; force_target = 32'h0000_0202;
        cycle();
        pop_log.delete();
`ifdef IFETCH_ALIGN_FAULT_EN
        check("d_fault", {31'b0, fetch_fault}, 32'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid) n++;
            cycle();
        end
        check("d_no_requests", n, 32'd0);
`else
        n = 0;
        while (pop_log.size() == 0 && n < 40) begin cycle(); n++; end
        check("d_first_pc", (pop_log.size() != 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0200);
`endif

        // Randomized traffic; each segment begins with a reset taken mid-operation.
        for (int seg = 0; seg < 4; seg++) begin
            lat_min = 1; lat_max = 1 + seg;
            ready_pct = 55 + 10 * seg; mreq_pct = 60 + 10 * seg; redir_permille = 25;
            do_reset();
            repeat (700) cycle();
        end

        n = 0;
        while (!w_done && n < 100) begin @(negedge clk); n++; end
        check("w_done", {31'b0, w_done}, 32'd1);
        check("w_nreqs", {31'b0, (w_log.size() >= 3)}, 32'd1);
        if (w_log.size() >= 3) begin
            check("w_addr0", w_log[0], 32'hFFFF_FFF8);
            check("w_addr1", w_log[1], 32'hFFFF_FFFC);
            check("w_addr2", w_log[2], 32'h0000_0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
